// File: rtl/mdio_master.sv
// Clause-45 MDIO master: serialises 32-bit frame words onto MDC/MDIO and returns read data.
// Define MDIO_PRE_SUPPRESS_EN to skip the preamble for PHYs that support preamble suppression.
module mdio_master #(
    parameter int CLK_DIV  = 50,
    parameter int PRE_BITS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] acc_data,
    input  logic        acc_en,
    output logic        acc_en_ack,
    output logic        busy,
    output logic        mdc_o,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic        mdio_i,
    output logic [15:0] rd_data,
    output logic        rd_valid
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = (PRE_BITS > 32) ? $clog2(PRE_BITS) : 6;

    typedef enum logic [1:0] {IDLE, PRE, FRAME, DONE} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mdc_q, mdc_d;
    logic               mdio_o_q, mdio_o_d;
    logic               mdio_t_q, mdio_t_d;
    logic               ack_q, ack_d;
    logic               rd_op_q, rd_op_d;
    logic [15:0]        rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic [31:0]        shift_q, shift_d;
    logic [14:0]        cap_q, cap_d;

    logic tick, rise, fall, accept;

    always_comb begin
        tick   = (state_q != IDLE) && (div_q == DIV_W'(CLK_DIV - 1));
        rise   = tick && !mdc_q;
        fall   = tick && mdc_q;
        accept = (state_q == IDLE) && acc_en && !ack_q;

        state_d    = state_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        mdc_d      = mdc_q;
        mdio_o_d   = mdio_o_q;
        mdio_t_d   = mdio_t_q;
        ack_d      = ack_q;
        rd_op_d    = rd_op_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        shift_d    = shift_q;
        cap_d      = cap_q;

        // The acknowledge follows the requester's level, not frame progress.
        if (ack_q && !acc_en)
            ack_d = 1'b0;

        if (state_q != IDLE)
            div_d = tick ? '0 : div_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    ack_d    = 1'b1;
                    shift_d  = acc_data;
                    rd_op_d  = acc_data[29];
                    div_d    = '0;
                    mdc_d    = 1'b0;
                    mdio_t_d = 1'b0;
`ifdef MDIO_PRE_SUPPRESS_EN
                    state_d  = FRAME;
                    cnt_d    = CNT_W'(31);
                    mdio_o_d = acc_data[31];
`else
                    state_d  = PRE;
                    cnt_d    = CNT_W'(PRE_BITS - 1);
                    mdio_o_d = 1'b1;
`endif
                end
            end
            PRE: begin
                if (tick)
                    mdc_d = !mdc_q;
                if (fall) begin
                    if (cnt_q == '0) begin
                        state_d  = FRAME;
                        cnt_d    = CNT_W'(31);
                        mdio_o_d = shift_q[31];
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            FRAME: begin
                if (tick)
                    mdc_d = !mdc_q;
                if (rise && rd_op_q && (cnt_q < CNT_W'(16))) begin
                    cap_d = {cap_q[13:0], mdio_i};
                    if (cnt_q == '0) begin
                        rd_data_d  = {cap_q, mdio_i};
                        rd_valid_d = 1'b1;
                    end
                end
                if (fall) begin
                    if (cnt_q == '0) begin
                        state_d  = DONE;
                        cnt_d    = CNT_W'(1);
                        mdio_o_d = 1'b1;
                        mdio_t_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        shift_d = shift_q << 1;
                        // Reads hand the line to the PHY from the turnaround bit onward.
                        if (rd_op_q && (cnt_q <= CNT_W'(18))) begin
                            mdio_o_d = 1'b1;
                            mdio_t_d = 1'b1;
                        end else begin
                            mdio_o_d = shift_q[30];
                        end
                    end
                end
            end
            DONE: begin
                // MDC stays low for a full period; the counter marks both half-periods.
                if (tick) begin
                    if (cnt_q == '0)
                        state_d = IDLE;
                    else
                        cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            cnt_q      <= '0;
            mdc_q      <= 1'b0;
            mdio_o_q   <= 1'b1;
            mdio_t_q   <= 1'b1;
            ack_q      <= 1'b0;
            rd_op_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            mdc_q      <= mdc_d;
            mdio_o_q   <= mdio_o_d;
            mdio_t_q   <= mdio_t_d;
            ack_q      <= ack_d;
            rd_op_q    <= rd_op_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        cap_q   <= cap_d;
    end

    assign acc_en_ack = ack_q;
    assign busy       = (state_q != IDLE);
    assign mdc_o      = mdc_q;
    assign mdio_o     = mdio_o_q;
    assign mdio_t     = mdio_t_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_mdio_master.sv
// Scoreboard bench for mdio_master: requests queue expected frames, a bus monitor with a PHY model checks them.
module tb_mdio_master;
    localparam int CD = 4;
`ifdef MDIO_PRE_SUPPRESS_EN
    localparam int PRE_N = 0;
`else
    localparam int PRE_N = 32;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] acc_data;
    logic        acc_en;
    logic        acc_en_ack;
    logic        busy;
    logic        mdc_o;
    logic        mdio_o;
    logic        mdio_t;
    logic        mdio_i = 1'b1;
    logic [15:0] rd_data;
    logic        rd_valid;

    mdio_master #(.CLK_DIV(CD), .PRE_BITS(32)) dut (
        .clk(clk), .rst_n(rst_n), .acc_data(acc_data), .acc_en(acc_en),
        .acc_en_ack(acc_en_ack), .busy(busy), .mdc_o(mdc_o), .mdio_o(mdio_o),
        .mdio_t(mdio_t), .mdio_i(mdio_i), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [15:0] phy;
    } req_t;

    req_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          req_cnt = 0;
    int          ack_seen = 0;
    logic [15:0] last_rd = 16'h0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endfunction

    // Expected per-MDC-rise line state: preamble ones, then the word MSB first,
    // with reads releasing the line from the turnaround bit onward.
    function automatic void build_exp(input req_t r, output logic [63:0] et, output logic [63:0] eo);
        int   b;
        logic t, o;
        et = '0;
        eo = '0;
        for (int i = 0; i < PRE_N + 32; i++) begin
            if (i < PRE_N) begin
                t = 1'b0; o = 1'b1;
            end else begin
                b = 31 - (i - PRE_N);
                if (r.word[29] && b <= 17) begin
                    t = 1'b1; o = 1'b0;
                end else begin
                    t = 1'b0; o = r.word[b];
                end
            end
            et = {et[62:0], t};
            eo = {eo[62:0], o};
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mdc"},    64'(mdc_o), 64'd0);
        chk({tag, "_mdio_t"}, 64'(mdio_t), 64'd1);
        chk({tag, "_mdio_o"}, 64'(mdio_o), 64'd1);
        chk({tag, "_ack"},    64'(acc_en_ack), 64'd0);
        chk({tag, "_busy"},   64'(busy), 64'd0);
        chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
        chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    endtask

    task automatic issue(input logic [31:0] w, input logic [15:0] pw, input int hold);
        req_t r;
        logic prevb, late;
        int   n;
        r.word = w;
        r.phy  = pw;
        exp_q.push_back(r);
        @(negedge clk);
        acc_data = w;
        acc_en   = 1'b1;
        prevb    = busy;
        late     = 1'b0;
        n        = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (acc_en_ack) break;
            if (!prevb) late = 1'b1;
            prevb = busy;
        end
        if (!acc_en_ack) begin
            chk("ack_timeout", 64'd0, 64'd1);
        end else begin
            req_cnt++;
            chk("ack_after_idle", 64'(prevb), 64'd0);
            chk("ack_prompt", 64'(late), 64'd0);
        end
        acc_data = $urandom;
        repeat (hold) @(negedge clk);
        acc_en = 1'b0;
        @(negedge clk);
        chk("ack_drop", 64'(acc_en_ack), 64'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    initial begin : monitor
        logic        prev_busy, prev_mdc, prev_ack, in_frame;
        int          nrise, tot, ph, nvalid, b;
        logic [63:0] act_t, act_o, et, eo;
        req_t        cur;
        prev_busy = 1'b0; prev_mdc = 1'b0; prev_ack = 1'b0; in_frame = 1'b0;
        nrise = 0; tot = 0; ph = 0; nvalid = 0; b = 0;
        act_t = '0; act_o = '0;
        cur.word = '0; cur.phy = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                in_frame = 1'b0;
                last_rd  = 16'h0;
                mdio_i   = 1'b1;
            end else begin
                if (acc_en_ack && !prev_ack) ack_seen++;
                if (busy && !prev_busy) begin
                    chk("frame_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        in_frame = 1'b1;
                    end else begin
                        in_frame = 1'b0;
                    end
                    nrise = 0; tot = 0; ph = 0; nvalid = 0;
                    act_t = '0; act_o = '0;
                end else if (in_frame) begin
                    tot++;
                    ph++;
                    if (mdc_o !== prev_mdc) begin
                        chk("mdc_phase", 64'(ph), 64'(CD));
                        ph = 0;
                        if (mdc_o) begin
                            act_t = {act_t[62:0], mdio_t};
                            act_o = {act_o[62:0], mdio_o};
                            nrise++;
                        end else if (cur.word[29] && nrise >= PRE_N + 16 && nrise < PRE_N + 32) begin
                            b = 31 - (nrise - PRE_N);
                            mdio_i = cur.phy[b];
                        end else begin
                            mdio_i = 1'($urandom);
                        end
                    end
                    if (rd_valid) begin
                        nvalid++;
                        if (cur.word[29]) chk("rd_data", 64'(rd_data), 64'(cur.phy));
                    end
                    if (!busy) begin
                        chk("frame_rises", 64'(nrise), 64'(PRE_N + 32));
                        chk("frame_len", 64'(tot), 64'((PRE_N + 33) * 2 * CD));
                        chk("done_low", 64'(ph), 64'(2 * CD));
                        build_exp(cur, et, eo);
                        chk("frame_oe", act_t, et);
                        chk("frame_data", act_o & ~et, eo & ~et);
                        chk("rd_valid_cnt", 64'(nvalid), 64'(cur.word[29] ? 1 : 0));
                        chk("idle_release", 64'(mdio_t), 64'd1);
                        if (cur.word[29]) last_rd = cur.phy;
                        else chk("rd_data_hold", 64'(rd_data), 64'(last_rd));
                        in_frame = 1'b0;
                    end
                end else if (rd_valid) begin
                    chk("rd_valid_idle", 64'(rd_valid), 64'd0);
                end
            end
            prev_busy = busy;
            prev_mdc  = mdc_o;
            prev_ack  = acc_en_ack;
        end
    end

    initial begin : stim
        rst_n    = 1'b0;
        acc_en   = 1'b0;
        acc_data = '0;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'h0443_ABCD, 16'h0000, 2);
        wait_idle();
        issue(32'h3443_0000, 16'h5A5C, 3);
        wait_idle();

        issue(32'h0443_1111, 16'h0000, 0);
        repeat (40) @(negedge clk);
        issue(32'h3443_0000, 16'hC3A5, 1);
        wait_idle();

        issue(32'h3443_0000, 16'hBEEF, 0);
        repeat (2 * (PRE_N + 11) * CD - 1) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(32'h3001_0000, 16'h1E0F, 0);
        wait_idle();

        issue(32'h0443_2222, 16'h0000, 700);
        wait_idle();

        for (int k = 0; k < 12; k++) begin
            issue($urandom, 16'($urandom), $urandom_range(0, 6));
            if ($urandom_range(0, 2) == 0) wait_idle();
            else repeat ($urandom_range(0, 300)) @(negedge clk);
        end
        wait_idle();
        repeat (10) @(negedge clk);

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("ack_count", 64'(ack_seen), 64'(req_cnt));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
